c7bbiu_arb: RTL and testbench

Two-requester arbiter sharing the core's single external memory port between instruction fetch (IFU/icache miss path) and the load/store unit. Accepts one transaction at a time, sequences the request/ack/data-valid handshake on the memory side, steers responses back to the owner, and discards IFU responses cancelled by a pipeline flush (branch, exception, ertn). Sits between c7bifu/LSU and the bus interface.

---
 rtl/c7bbiu_arb.sv | 143 ++++++++++++++
 tb/tb_c7bbiu_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c7bbiu_arb.sv
// Shares the single external memory port between IFU fetch and LSU, one transaction at a time.
// Build option C7B_ARB_RR_EN selects round-robin; otherwise fixed LSU priority with a starvation counter.
module c7bbiu_arb #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_arb_req,
  input  logic [31:0] ifu_arb_addr,
  input  logic        ifu_arb_cancel,
  output logic        arb_ifu_ack,
  output logic        arb_ifu_data_valid,
  output logic [63:0] arb_ifu_data,
  input  logic        lsu_arb_req,
  input  logic        lsu_arb_wr,
  input  logic [31:0] lsu_arb_addr,
  input  logic [63:0] lsu_arb_wdata,
  input  logic [7:0]  lsu_arb_wstrb,
  output logic        arb_lsu_ack,
  output logic        arb_lsu_data_valid,
  output logic [63:0] arb_lsu_data,
  output logic        arb_mem_req,
  output logic        arb_mem_wr,
  output logic [31:0] arb_mem_addr,
  output logic [63:0] arb_mem_wdata,
  output logic [7:0]  arb_mem_wstrb,
  input  logic        mem_arb_ack,
  input  logic        mem_arb_data_valid,
  input  logic [63:0] mem_arb_data,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req and its fields until its ack; ack is the
  // memory ack passed through combinationally while this arbiter is in REQ for
  // that owner; data_valid is a single-cycle pulse qualifying arb_*_data.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   drop, drop_nxt;
  logic   arb_pt, any_req, grant_lsu, in_req, resp;

`ifndef C7B_ARB_RR_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= OWN_IFU;
      drop  <= 1'b0;
`ifndef C7B_ARB_RR_EN
      starve_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      drop  <= drop_nxt;
`ifndef C7B_ARB_RR_EN
      starve_cnt <= starve_cnt_nxt;
`endif
    end
  end

  assign any_req = ifu_arb_req | lsu_arb_req;

`ifdef C7B_ARB_RR_EN
  // On a tie the previous owner yields.
  assign grant_lsu = (ifu_arb_req & lsu_arb_req) ? (owner == OWN_IFU) : lsu_arb_req;
`else
  assign grant_lsu = lsu_arb_req & ~(ifu_arb_req & starved);
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    drop_nxt  = drop;
`ifndef C7B_ARB_RR_EN
    starve_cnt_nxt = starve_cnt;
`endif
    arb_pt = 1'b0;
    case (state)
      IDLE:    arb_pt = 1'b1;
      REQ:     if (mem_arb_ack) state_nxt = WAIT;
      WAIT:    arb_pt = mem_arb_data_valid;
      default: state_nxt = IDLE;
    endcase

    if (arb_pt) begin
      drop_nxt = 1'b0;
      if (any_req) begin
        state_nxt = REQ;
        owner_nxt = grant_lsu ? OWN_LSU : OWN_IFU;
`ifndef C7B_ARB_RR_EN
        if (grant_lsu && ifu_arb_req) starve_cnt_nxt = starve_cnt + 1'b1;
        else                          starve_cnt_nxt = '0;
`endif
      end else begin
        state_nxt = IDLE;
      end
    end else if ((state == REQ || state == WAIT) && owner == OWN_IFU && ifu_arb_cancel) begin
      // Cancelled fetch still completes on the memory side; only its beat is discarded.
      drop_nxt = 1'b1;
    end
  end

  assign in_req = (state == REQ);
  assign resp   = (state == WAIT) & mem_arb_data_valid;

  always_comb begin
    arb_mem_req   = in_req;
    arb_mem_wr    = 1'b0;
    arb_mem_addr  = '0;
    arb_mem_wdata = '0;
    arb_mem_wstrb = '0;
    if (in_req) begin
      if (owner == OWN_LSU) begin
        arb_mem_wr    = lsu_arb_wr;
        arb_mem_addr  = lsu_arb_addr;
        arb_mem_wdata = lsu_arb_wdata;
        arb_mem_wstrb = lsu_arb_wstrb;
      end else begin
        arb_mem_addr  = ifu_arb_addr;
      end
    end
  end

  assign arb_ifu_ack        = in_req & (owner == OWN_IFU) & mem_arb_ack;
  assign arb_lsu_ack        = in_req & (owner == OWN_LSU) & mem_arb_ack;
  assign arb_ifu_data_valid = resp & (owner == OWN_IFU) & ~drop & ~ifu_arb_cancel;
  assign arb_lsu_data_valid = resp & (owner == OWN_LSU);
  assign arb_ifu_data       = mem_arb_data;
  assign arb_lsu_data       = mem_arb_data;
  assign dbg_state          = state;

endmodule

// File: tb/tb_c7bbiu_arb.sv
// Self-checking bench for c7bbiu_arb: directed scenarios plus a response scoreboard.
// Honors C7B_ARB_RR_EN for the expected grant pattern.
module tb_c7bbiu_arb;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ifu_arb_req = 1'b0;
  logic [31:0] ifu_arb_addr = '0;
  logic        ifu_arb_cancel = 1'b0;
  logic        arb_ifu_ack, arb_ifu_data_valid;
  logic [63:0] arb_ifu_data;
  logic        lsu_arb_req = 1'b0;
  logic        lsu_arb_wr = 1'b0;
  logic [31:0] lsu_arb_addr = '0;
  logic [63:0] lsu_arb_wdata = '0;
  logic [7:0]  lsu_arb_wstrb = '0;
  logic        arb_lsu_ack, arb_lsu_data_valid;
  logic [63:0] arb_lsu_data;
  logic        arb_mem_req, arb_mem_wr;
  logic [31:0] arb_mem_addr;
  logic [63:0] arb_mem_wdata;
  logic [7:0]  arb_mem_wstrb;
  logic        mem_arb_ack = 1'b0;
  logic        mem_arb_data_valid = 1'b0;
  logic [63:0] mem_arb_data = '0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] ifu_q[$];
  logic [63:0] lsu_q[$];

  c7bbiu_arb #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .resetn(resetn),
    .ifu_arb_req(ifu_arb_req), .ifu_arb_addr(ifu_arb_addr), .ifu_arb_cancel(ifu_arb_cancel),
    .arb_ifu_ack(arb_ifu_ack), .arb_ifu_data_valid(arb_ifu_data_valid), .arb_ifu_data(arb_ifu_data),
    .lsu_arb_req(lsu_arb_req), .lsu_arb_wr(lsu_arb_wr), .lsu_arb_addr(lsu_arb_addr),
    .lsu_arb_wdata(lsu_arb_wdata), .lsu_arb_wstrb(lsu_arb_wstrb),
    .arb_lsu_ack(arb_lsu_ack), .arb_lsu_data_valid(arb_lsu_data_valid), .arb_lsu_data(arb_lsu_data),
    .arb_mem_req(arb_mem_req), .arb_mem_wr(arb_mem_wr), .arb_mem_addr(arb_mem_addr),
    .arb_mem_wdata(arb_mem_wdata), .arb_mem_wstrb(arb_mem_wstrb),
    .mem_arb_ack(mem_arb_ack), .mem_arb_data_valid(mem_arb_data_valid), .mem_arb_data(mem_arb_data),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    resetn = 1'b0;
    ifu_arb_req = 1'b0; ifu_arb_addr = '0; ifu_arb_cancel = 1'b0;
    lsu_arb_req = 1'b0; lsu_arb_wr = 1'b0; lsu_arb_addr = '0; lsu_arb_wdata = '0; lsu_arb_wstrb = '0;
    mem_arb_ack = 1'b0; mem_arb_data_valid = 1'b0; mem_arb_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every data_valid must match the head of the owner's queue.
  always @(negedge clk) begin
    if (arb_ifu_data_valid) begin
      n_checks++;
      if (ifu_q.size() == 0) begin
        n_fail++;
        $display("FAIL ifu_resp: unexpected valid data=%h, required no response", arb_ifu_data);
      end else begin
        logic [63:0] e;
        e = ifu_q.pop_front();
        if (arb_ifu_data !== e) begin
          n_fail++;
          $display("FAIL ifu_resp: got %h required %h", arb_ifu_data, e);
        end
      end
    end
    if (arb_lsu_data_valid) begin
      n_checks++;
      if (lsu_q.size() == 0) begin
        n_fail++;
        $display("FAIL lsu_resp: unexpected valid data=%h, required no response", arb_lsu_data);
      end else begin
        logic [63:0] e;
        e = lsu_q.pop_front();
        if (arb_lsu_data !== e) begin
          n_fail++;
          $display("FAIL lsu_resp: got %h required %h", arb_lsu_data, e);
        end
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    n_checks++;
    if ({arb_mem_req, arb_mem_wr, arb_mem_addr, arb_mem_wdata, arb_mem_wstrb} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_port: req=%b wr=%b addr=%h wdata=%h wstrb=%h required all 0",
               arb_mem_req, arb_mem_wr, arb_mem_addr, arb_mem_wdata, arb_mem_wstrb);
    end
    n_checks++;
    if ({arb_ifu_ack, arb_ifu_data_valid, arb_lsu_ack, arb_lsu_data_valid, dbg_state} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: acks/valids/state=%b required 0",
               {arb_ifu_ack, arb_ifu_data_valid, arb_lsu_ack, arb_lsu_data_valid, dbg_state});
    end
    do_reset();
  endtask

  task automatic test_ifu_read();
    do_reset();
    step(); ifu_arb_req = 1'b1; ifu_arb_addr = 32'h1c00_0000;
    @(negedge clk);
    n_checks++;
    if (arb_mem_req !== 1'b0) begin n_fail++; $display("FAIL ifu_req_latency: mem_req=%b required 0", arb_mem_req); end
    step(); mem_arb_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({arb_mem_req, arb_ifu_ack, arb_lsu_ack, arb_mem_wr} !== 4'b1100 || arb_mem_addr !== 32'h1c00_0000 ||
        arb_mem_wstrb !== 8'h00) begin
      n_fail++;
      $display("FAIL ifu_req: req/iack/lack/wr=%b addr=%h wstrb=%h required 1100 1c000000 00",
               {arb_mem_req, arb_ifu_ack, arb_lsu_ack, arb_mem_wr}, arb_mem_addr, arb_mem_wstrb);
    end
    step(); mem_arb_ack = 1'b0; ifu_arb_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (arb_mem_req !== 1'b0 || arb_mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL ifu_wait_fields: req=%b addr=%h required 0 0", arb_mem_req, arb_mem_addr);
    end
    step(); mem_arb_data_valid = 1'b1; mem_arb_data = 64'h1122_3344_5566_7788;
    ifu_q.push_back(64'h1122_3344_5566_7788);
    @(negedge clk);
    n_checks++;
    if (arb_ifu_data_valid !== 1'b1 || arb_lsu_data_valid !== 1'b0 || arb_lsu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL ifu_valid_cycle: ifu_dv=%b lsu_dv=%b lsu_ack=%b required 1 0 0",
               arb_ifu_data_valid, arb_lsu_data_valid, arb_lsu_ack);
    end
    step(); mem_arb_data_valid = 1'b0;
  endtask

  task automatic test_starvation();
    logic exp_lsu;
    do_reset();
    step(); ifu_arb_req = 1'b1; ifu_arb_addr = 32'h1c00_0100;
    lsu_arb_req = 1'b1; lsu_arb_wr = 1'b0; lsu_arb_addr = 32'h0000_0200;
    for (int k = 0; k < 19; k++) begin
`ifdef C7B_ARB_RR_EN
      exp_lsu = (k % 2 == 0);
`else
      exp_lsu = (k % 9 != 8);
`endif
      step(); mem_arb_ack = 1'b1; mem_arb_data_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (arb_lsu_ack !== exp_lsu || arb_ifu_ack !== !exp_lsu) begin
        n_fail++;
        $display("FAIL grant_%0d: lsu_ack=%b ifu_ack=%b required lsu_ack=%b", k, arb_lsu_ack, arb_ifu_ack, exp_lsu);
      end
      step(); mem_arb_ack = 1'b0; mem_arb_data_valid = 1'b1;
      mem_arb_data = 64'hA5A5_0000_0000_0000 | 64'(k);
      if (exp_lsu) lsu_q.push_back(64'hA5A5_0000_0000_0000 | 64'(k));
      else         ifu_q.push_back(64'hA5A5_0000_0000_0000 | 64'(k));
      if (k == 18) begin ifu_arb_req = 1'b0; lsu_arb_req = 1'b0; end
      @(negedge clk);
    end
    step(); mem_arb_data_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL starve_idle: state=%0d required 0", dbg_state); end
  endtask

  task automatic test_cancel_wait();
    do_reset();
    step(); ifu_arb_req = 1'b1; ifu_arb_addr = 32'h1c00_0000;
    step(); mem_arb_ack = 1'b1;
    step(); mem_arb_ack = 1'b0; ifu_arb_req = 1'b0; ifu_arb_cancel = 1'b1;
    step(); ifu_arb_cancel = 1'b0;
    step(); mem_arb_data_valid = 1'b1; mem_arb_data = 64'hBAD0_BAD0_BAD0_BAD0;
    ifu_arb_req = 1'b1; ifu_arb_addr = 32'h1c00_0040;
    @(negedge clk);
    n_checks++;
    if (arb_ifu_data_valid !== 1'b0) begin n_fail++; $display("FAIL cancel_wait_drop: ifu_dv=%b required 0", arb_ifu_data_valid); end
    step(); mem_arb_data_valid = 1'b0; mem_arb_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (arb_mem_req !== 1'b1 || arb_mem_addr !== 32'h1c00_0040 || arb_ifu_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL cancel_next_req: req=%b addr=%h ack=%b required 1 1c000040 1", arb_mem_req, arb_mem_addr, arb_ifu_ack);
    end
    step(); mem_arb_ack = 1'b0; ifu_arb_req = 1'b0;
    step(); mem_arb_data_valid = 1'b1; mem_arb_data = 64'h0102_0304_0506_0708;
    ifu_q.push_back(64'h0102_0304_0506_0708);
    step(); mem_arb_data_valid = 1'b0;
  endtask

  task automatic test_cancel_req();
    do_reset();
    step(); ifu_arb_req = 1'b1; ifu_arb_addr = 32'h1c00_0080;
    step(); ifu_arb_cancel = 1'b1;
    @(negedge clk);
    n_checks++;
    if (arb_mem_req !== 1'b1) begin n_fail++; $display("FAIL cancel_req_hold0: mem_req=%b required 1", arb_mem_req); end
    step(); ifu_arb_cancel = 1'b0;
    @(negedge clk);
    n_checks++;
    if (arb_mem_req !== 1'b1 || arb_mem_addr !== 32'h1c00_0080) begin
      n_fail++; $display("FAIL cancel_req_hold1: mem_req=%b addr=%h required 1 1c000080", arb_mem_req, arb_mem_addr);
    end
    step(); mem_arb_ack = 1'b1;
    step(); mem_arb_ack = 1'b0; ifu_arb_req = 1'b0;
    step(); mem_arb_data_valid = 1'b1; mem_arb_data = 64'hDEAD_0000_DEAD_0000;
    @(negedge clk);
    n_checks++;
    if (arb_ifu_data_valid !== 1'b0) begin n_fail++; $display("FAIL cancel_req_drop: ifu_dv=%b required 0", arb_ifu_data_valid); end
    step(); mem_arb_data_valid = 1'b0;
  endtask

  task automatic test_cancel_misc();
    // Cancel coincident with the beat drops it.
    do_reset();
    step(); ifu_arb_req = 1'b1; ifu_arb_addr = 32'h1c00_00c0;
    step(); mem_arb_ack = 1'b1;
    step(); mem_arb_ack = 1'b0; ifu_arb_req = 1'b0;
    step(); mem_arb_data_valid = 1'b1; ifu_arb_cancel = 1'b1; mem_arb_data = 64'h5555_5555_5555_5555;
    @(negedge clk);
    n_checks++;
    if (arb_ifu_data_valid !== 1'b0) begin n_fail++; $display("FAIL cancel_beat: ifu_dv=%b required 0", arb_ifu_data_valid); end
    step(); mem_arb_data_valid = 1'b0; ifu_arb_cancel = 1'b0;
    // Cancel during an LSU transaction has no effect.
    step(); lsu_arb_req = 1'b1; lsu_arb_wr = 1'b0; lsu_arb_addr = 32'h0000_0300;
    step(); mem_arb_ack = 1'b1;
    step(); mem_arb_ack = 1'b0; lsu_arb_req = 1'b0; ifu_arb_cancel = 1'b1;
    step(); mem_arb_data_valid = 1'b1; mem_arb_data = 64'h7777_6666_5555_4444;
    lsu_q.push_back(64'h7777_6666_5555_4444);
    @(negedge clk);
    n_checks++;
    if (arb_lsu_data_valid !== 1'b1) begin n_fail++; $display("FAIL cancel_lsu: lsu_dv=%b required 1", arb_lsu_data_valid); end
    step(); mem_arb_data_valid = 1'b0; ifu_arb_cancel = 1'b0;
  endtask

  task automatic test_lsu_write();
    logic [31:0] a;
    logic [63:0] wd;
    do_reset();
    a = 32'h0000_0100;
    wd = {$urandom(), $urandom()};
    step(); lsu_arb_req = 1'b1; lsu_arb_wr = 1'b1; lsu_arb_addr = a; lsu_arb_wdata = wd; lsu_arb_wstrb = 8'h0F;
    step(); mem_arb_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({arb_mem_req, arb_mem_wr, arb_lsu_ack, arb_ifu_ack} !== 4'b1110 || arb_mem_addr !== a ||
        arb_mem_wdata !== wd || arb_mem_wstrb !== 8'h0F) begin
      n_fail++;
      $display("FAIL lsu_write_fields: req/wr/lack/iack=%b addr=%h wdata=%h wstrb=%h required 1110 %h %h 0f",
               {arb_mem_req, arb_mem_wr, arb_lsu_ack, arb_ifu_ack}, arb_mem_addr, arb_mem_wdata, arb_mem_wstrb, a, wd);
    end
    step(); mem_arb_ack = 1'b0; lsu_arb_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({arb_mem_wr, arb_mem_wdata, arb_mem_wstrb} !== '0) begin
      n_fail++; $display("FAIL lsu_write_idle_fields: wr=%b wdata=%h wstrb=%h required 0", arb_mem_wr, arb_mem_wdata, arb_mem_wstrb);
    end
    step(); mem_arb_data_valid = 1'b1; mem_arb_data = 64'h0;
    lsu_q.push_back(64'h0);
    step(); mem_arb_data_valid = 1'b0;
  endtask

  task automatic test_reset_wait();
    do_reset();
    step(); ifu_arb_req = 1'b1; ifu_arb_addr = 32'h1c00_0100;
    step(); mem_arb_ack = 1'b1;
    step(); mem_arb_ack = 1'b0; ifu_arb_req = 1'b0;
    #2 resetn = 1'b0; mem_arb_data_valid = 1'b1; mem_arb_data = 64'hFFFF_0000_FFFF_0000;
    #1;
    n_checks++;
    if ({dbg_state, arb_mem_req, arb_ifu_data_valid, arb_lsu_data_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_in_wait: state/req/idv/ldv=%b required 0",
               {dbg_state, arb_mem_req, arb_ifu_data_valid, arb_lsu_data_valid});
    end
    do_reset();
    step(); lsu_arb_req = 1'b1; lsu_arb_wr = 1'b0; lsu_arb_addr = 32'h0000_0400;
    @(negedge clk);
    n_checks++;
    if (arb_mem_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: mem_req=%b required 0", arb_mem_req); end
    step(); mem_arb_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (arb_lsu_ack !== 1'b1 || arb_mem_addr !== 32'h0000_0400) begin
      n_fail++; $display("FAIL post_reset_req: ack=%b addr=%h required 1 00000400", arb_lsu_ack, arb_mem_addr);
    end
    step(); mem_arb_ack = 1'b0; lsu_arb_req = 1'b0;
    step(); mem_arb_data_valid = 1'b1; mem_arb_data = 64'h0BAD_CAFE_0000_1234;
    lsu_q.push_back(64'h0BAD_CAFE_0000_1234);
    step(); mem_arb_data_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_starvation();
    test_cancel_wait();
    test_cancel_req();
    test_cancel_misc();
    test_lsu_write();
    test_reset_wait();
    repeat (2) @(posedge clk);
    n_checks++;
    if (ifu_q.size() != 0 || lsu_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_responses: ifu_q=%0d lsu_q=%0d required 0 0", ifu_q.size(), lsu_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
